life_grid_engine: RTL and testbench

Parametrised Life-like cellular automaton engine: a ROWS x COLS cell grid held in registers and advanced a requested number of generations under a programmable birth/survive rule. It replaces the fixed-size, rule-only generation block under `top` and adds three things: a row load/read port, a toroidal or dead-edge boundary mode, and an early stop when the grid stops changing. The testbench and host logic load a pattern, pulse `start`, and wait for `update_done`.

---
 rtl/life_grid_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_life_grid_engine.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_grid_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : life_grid_engine
//  Purpose  : Life-like cellular automaton engine. A ROWS x COLS grid is held
//             in registers and advanced a requested number of generations
//             under a programmable birth/survive rule. One grid row is
//             evaluated per clock. The run stops early if a generation leaves
//             the grid unchanged.
//
//  Ports    : clk          - clock, rising edge
//             rst_n        - asynchronous active-low reset
//             rule         - [8:0] survive mask, [24:16] birth mask
//             load_en      - write load_data into row load_row (idle only)
//             load_row     - row index for load
//             load_data    - row contents, bit c = column c
//             start        - begin a run (idle only, ignored while load_en)
//             num_gens     - generations to run, sampled on start
//             rd_row       - row index to read
//             rd_data      - committed row rd_row, one cycle latency
//             busy         - run in progress
//             update_done  - one-cycle pulse at end of run
//             stable       - last run stopped because nothing changed
//             gen_count    - generations committed in current/last run
//
//  Revision : 1.0  initial release
// ============================================================================
module life_grid_engine #(
    parameter  int COLS = 16,
    parameter  int ROWS = 16,
    parameter  int WRAP = 1,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     rule,
    input  logic            load_en,
    input  logic [RW-1:0]   load_row,
    input  logic [COLS-1:0] load_data,
    input  logic            start,
    input  logic [15:0]     num_gens,
    input  logic [RW-1:0]   rd_row,
    output logic [COLS-1:0] rd_data,
    output logic            busy,
    output logic            update_done,
    output logic            stable,
    output logic [15:0]     gen_count
);

    localparam logic          c_wrap     = (WRAP != 0);
    localparam logic [RW-1:0] c_last_row = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_COMMIT  = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          r_state;
    logic [COLS-1:0] r_cur [ROWS];   // committed, visible grid
    logic [COLS-1:0] r_nxt [ROWS];   // next generation under construction
    logic [RW-1:0]   r_row;
    logic            r_changed;
    logic [15:0]     r_num_gens;
    logic [COLS-1:0] r_rd_data;
    logic            r_busy;
    logic            r_update_done;
    logic            r_stable;
    logic [15:0]     r_gen_count;

    logic [COLS-1:0] w_row_above;
    logic [COLS-1:0] w_row_here;
    logic [COLS-1:0] w_row_below;
    logic [COLS-1:0] w_new_row;
    logic            w_row_changed;
    logic            w_rd_ok;
    logic            w_load_ok;
    logic [15:0]     w_gen_next;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

    // Row indices are RW bits wide, which can exceed ROWS when ROWS is not a
    // power of two; compare in 32 bits so the check is meaningful everywhere.
    function automatic logic row_in_range(input logic [RW-1:0] idx);
        int unsigned v;
        v = 32'(idx);
        return (v < ROWS);
    endfunction

    assign w_rd_ok    = row_in_range(rd_row);
    assign w_load_ok  = row_in_range(load_row);
    assign w_gen_next = r_gen_count + 16'd1;

    // ------------------------------------------------------------------------
    // Neighbour rows for the row being evaluated. At the top/bottom edge the
    // missing row either wraps around or reads as all-dead.
    // ------------------------------------------------------------------------
    always_comb begin
        w_row_here  = r_cur[r_row];
        w_row_above = '0;
        w_row_below = '0;
        if (r_row != '0) begin
            w_row_above = r_cur[r_row - RW'(1)];
        end else if (c_wrap) begin
            w_row_above = r_cur[ROWS-1];
        end
        if (r_row != c_last_row) begin
            w_row_below = r_cur[r_row + RW'(1)];
        end else if (c_wrap) begin
            w_row_below = r_cur[0];
        end
    end

    // ------------------------------------------------------------------------
    // Per-column rule evaluation. Left/right neighbour columns are fixed at
    // elaboration; in dead-edge mode the out-of-grid side is masked off.
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int   CL     = (c == 0) ? COLS - 1 : c - 1;
        localparam int   CR     = (c == COLS - 1) ? 0 : c + 1;
        localparam logic c_l_ok = (WRAP != 0) || (c != 0);
        localparam logic c_r_ok = (WRAP != 0) || (c != COLS - 1);

        logic [7:0] w_nbrs;
        logic [3:0] w_cnt;

        assign w_nbrs = {w_row_above[CL] & c_l_ok, w_row_above[c], w_row_above[CR] & c_r_ok,
                         w_row_here[CL]  & c_l_ok,                 w_row_here[CR]  & c_r_ok,
                         w_row_below[CL] & c_l_ok, w_row_below[c], w_row_below[CR] & c_r_ok};
        assign w_cnt  = popcount8(w_nbrs);

        // Live cells look up the survive mask, dead cells the birth mask.
        assign w_new_row[c] = w_row_here[c] ? rule[{1'b0, w_cnt}]
                                            : rule[5'd16 + {1'b0, w_cnt}];
    end

    assign w_row_changed = (w_new_row != w_row_here);

    // ------------------------------------------------------------------------
    // Control FSM and grid storage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_row         <= '0;
            r_changed     <= 1'b0;
            r_num_gens    <= '0;
            r_rd_data     <= '0;
            r_busy        <= 1'b0;
            r_update_done <= 1'b0;
            r_stable      <= 1'b0;
            r_gen_count   <= '0;
            for (int i = 0; i < ROWS; i++) begin
                r_cur[i] <= '0;
                r_nxt[i] <= '0;
            end
        end else begin
            r_rd_data     <= w_rd_ok ? r_cur[rd_row] : '0;
            r_update_done <= 1'b0;

            case (r_state)
                // FINISH behaves like IDLE for host requests: busy is already
                // low there, so a load or start is taken immediately.
                S_IDLE, S_FINISH: begin
                    r_state <= S_IDLE;
                    if (load_en) begin
                        if (w_load_ok) begin
                            r_cur[load_row] <= load_data;
                        end
                    end else if (start) begin
                        r_gen_count <= '0;
                        r_stable    <= 1'b0;
                        r_num_gens  <= num_gens;
                        if (num_gens == 16'd0) begin
                            r_state       <= S_FINISH;
                            r_update_done <= 1'b1;
                        end else begin
                            r_state   <= S_COMPUTE;
                            r_busy    <= 1'b1;
                            r_row     <= '0;
                            r_changed <= 1'b0;
                        end
                    end
                end

                S_COMPUTE: begin
                    r_nxt[r_row] <= w_new_row;
                    r_changed    <= r_changed | w_row_changed;
                    if (r_row == c_last_row) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end

                S_COMMIT: begin
                    for (int i = 0; i < ROWS; i++) begin
                        r_cur[i] <= r_nxt[i];
                    end
                    r_gen_count <= w_gen_next;
                    if (!r_changed || (w_gen_next == r_num_gens)) begin
                        r_stable      <= !r_changed;
                        r_state       <= S_FINISH;
                        r_update_done <= 1'b1;
                        r_busy        <= 1'b0;
                    end else begin
                        r_changed <= 1'b0;
                        r_row     <= '0;
                        r_state   <= S_COMPUTE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_data     = r_rd_data;
    assign busy        = r_busy;
    assign update_done = r_update_done;
    assign stable      = r_stable;
    assign gen_count   = r_gen_count;

endmodule
`default_nettype wire

// File: tb/tb_life_grid_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_life_grid_engine
//  Purpose  : Self-checking bench for life_grid_engine. Two instances share
//             inputs: one toroidal (WRAP=1), one dead-edge (WRAP=0). Each run
//             pushes its expected result into a queue; a monitor pops it on
//             update_done and checks timing, status and the full grid.
//  Revision : 1.0  initial release
// ============================================================================
module tb_life_grid_engine;

    localparam logic [31:0] B3S23 = 32'h0008_000C;
    localparam logic [31:0] B1S0  = 32'h0002_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] rule;
    logic        le1, le0, st1, st0;
    logic [3:0]  load_row;
    logic [15:0] load_data;
    logic [15:0] num_gens;
    logic [3:0]  stim_row, mon_row, rd_row;
    logic        mon_reading;

    logic [15:0] rd1, rd0, gc1, gc0;
    logic        busy1, busy0, ud1, ud0, sb1, sb0;

    assign rd_row = mon_reading ? mon_row : stim_row;

    life_grid_engine #(.COLS(16), .ROWS(16), .WRAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .rule(rule),
        .load_en(le1), .load_row(load_row), .load_data(load_data),
        .start(st1), .num_gens(num_gens), .rd_row(rd_row), .rd_data(rd1),
        .busy(busy1), .update_done(ud1), .stable(sb1), .gen_count(gc1)
    );

    life_grid_engine #(.COLS(16), .ROWS(16), .WRAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rule(rule),
        .load_en(le0), .load_row(load_row), .load_data(load_data),
        .start(st0), .num_gens(num_gens), .rd_row(rd_row), .rd_data(rd0),
        .busy(busy0), .update_done(ud0), .stable(sb0), .gen_count(gc0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic         inst;
        logic [31:0]  due;
        logic [15:0]  gc;
        logic         st;
        logic [255:0] grid;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mon_done = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] put(input logic [255:0] g, input int r, input int c);
        logic [255:0] t;
        t = g;
        t[r*16 + c] = 1'b1;
        return t;
    endfunction

    // ------------------------------------------------------------------------
    // Monitor: pops one expectation per update_done pulse, then reads the grid
    // of the instance that finished.
    // ------------------------------------------------------------------------
    initial begin
        exp_t         e;
        logic [255:0] g;
        mon_reading = 1'b0;
        mon_row     = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && (ud1 === 1'b1 || ud0 === 1'b1)) begin
                if (q.size() == 0) begin
                    chk("spurious_update_done", 256'({ud1, ud0}), 256'(0));
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", 256'(cyc), 256'(e.due));
                    chk("busy_at_done", 256'(e.inst ? busy1 : busy0), 256'(0));
                    chk("gen_count", 256'(e.inst ? gc1 : gc0), 256'(e.gc));
                    chk("stable", 256'(e.inst ? sb1 : sb0), 256'(e.st));
                    mon_reading = 1'b1;
                    for (int i = 0; i < 16; i++) begin
                        mon_row = 4'(i);
                        @(negedge clk);
                        g[i*16 +: 16] = e.inst ? rd1 : rd0;
                    end
                    mon_reading = 1'b0;
                    chk("grid", g, e.grid);
                    mon_done++;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus tasks
    // ------------------------------------------------------------------------
    task automatic load_grid(input logic inst, input logic [255:0] g);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (inst) le1 = 1'b1; else le0 = 1'b1;
            load_row  = 4'(i);
            load_data = g[i*16 +: 16];
        end
        @(negedge clk);
        le1 = 1'b0;
        le0 = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int m0;
        bit got;
        m0  = mon_done;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (mon_done != m0) got = 1'b1;
        end
        if (!got) begin
            chk("run_completed", 256'(0), 256'(1));
            q.delete();
        end
    endtask

    // egc is the number of generations expected to commit; the done pulse is
    // due egc*(ROWS+1) cycles after the start edge's own output cycle.
    task automatic run(input logic inst, input logic [15:0] n, input logic [31:0] rl,
                       input logic [15:0] egc, input logic est, input logic [255:0] eg,
                       input bit poke);
        exp_t e;
        int   lat;
        lat = int'(egc) * 17;
        @(negedge clk);
        rule     = rl;
        num_gens = n;
        e.inst   = inst;
        e.due    = 32'(cyc + 1 + lat);
        e.gc     = egc;
        e.st     = est;
        e.grid   = eg;
        q.push_back(e);
        if (inst) st1 = 1'b1; else st0 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        st0 = 1'b0;
        if (poke) begin
            // Host requests while busy: both must be dropped, not queued.
            repeat (4) @(negedge clk);
            st1       = 1'b1;
            le1       = 1'b1;
            load_row  = 4'd0;
            load_data = 16'hFFFF;
            @(negedge clk);
            st1 = 1'b0;
            le1 = 1'b0;
        end
        wait_done(lat + 48);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------------
    initial begin
        logic [255:0] gv, gh, g0, g1, blk, one, ring, wr, wr_exp, g;
        int nud;

        rst_n = 1'b0; rule = B3S23; le1 = 0; le0 = 0; st1 = 0; st0 = 0;
        load_row = '0; load_data = '0; num_gens = '0; stim_row = '0;

        gv = '0; gv = put(gv, 7, 8); gv = put(gv, 8, 8); gv = put(gv, 9, 8);
        gh = '0; gh = put(gh, 8, 7); gh = put(gh, 8, 8); gh = put(gh, 8, 9);
        g0 = '0; g0 = put(g0, 1, 2); g0 = put(g0, 2, 3); g0 = put(g0, 3, 1);
                 g0 = put(g0, 3, 2); g0 = put(g0, 3, 3);
        g1 = '0; g1 = put(g1, 2, 3); g1 = put(g1, 3, 4); g1 = put(g1, 4, 2);
                 g1 = put(g1, 4, 3); g1 = put(g1, 4, 4);
        blk = '0; blk = put(blk, 5, 5); blk = put(blk, 5, 6);
                  blk = put(blk, 6, 5); blk = put(blk, 6, 6);
        one = '0; one = put(one, 8, 8);
        ring = '0;
        for (int r = 7; r <= 9; r++)
            for (int c = 7; c <= 9; c++)
                if (!(r == 8 && c == 8)) ring = put(ring, r, c);
        // Horizontal bar crossing the column edge plus a vertical bar
        // crossing the row edge.
        wr = '0; wr = put(wr, 5, 15); wr = put(wr, 5, 0); wr = put(wr, 5, 1);
                 wr = put(wr, 15, 8); wr = put(wr, 0, 8); wr = put(wr, 1, 8);
        wr_exp = '0; wr_exp = put(wr_exp, 4, 0); wr_exp = put(wr_exp, 5, 0);
                     wr_exp = put(wr_exp, 6, 0); wr_exp = put(wr_exp, 0, 7);
                     wr_exp = put(wr_exp, 0, 8); wr_exp = put(wr_exp, 0, 9);

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_busy", 256'(busy1), 256'(0));
        chk("reset_update_done", 256'(ud1), 256'(0));
        chk("reset_stable", 256'(sb1), 256'(0));
        chk("reset_gen_count", 256'(gc1), 256'(0));
        chk("reset_rd_data", 256'(rd1), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Load to read latency: visible two cycles after load_en
        @(negedge clk);
        le1 = 1'b1; load_row = 4'd3; load_data = 16'hA5C3; stim_row = 4'd3;
        @(negedge clk);
        le1 = 1'b0;
        chk("load_not_yet_visible", 256'(rd1), 256'(0));
        @(negedge clk);
        chk("load_visible", 256'(rd1), 256'(16'hA5C3));

        // Blinker
        load_grid(1'b1, gv);
        run(1'b1, 16'd1, B3S23, 16'd1, 1'b0, gh, 1'b0);
        load_grid(1'b1, gv);
        run(1'b1, 16'd2, B3S23, 16'd2, 1'b0, gv, 1'b1);

        // Glider on the torus
        load_grid(1'b1, g0);
        run(1'b1, 16'd4, B3S23, 16'd4, 1'b0, g1, 1'b0);
        load_grid(1'b1, g0);
        run(1'b1, 16'd64, B3S23, 16'd64, 1'b0, g0, 1'b0);

        // Still life stops after one generation
        load_grid(1'b1, blk);
        run(1'b1, 16'd100, B3S23, 16'd1, 1'b1, blk, 1'b0);

        // Zero generations: immediate done, grid untouched, stable cleared
        run(1'b1, 16'd0, B3S23, 16'd0, 1'b0, blk, 1'b0);

        // B1/S- from a single cell
        load_grid(1'b1, one);
        run(1'b1, 16'd1, B1S0, 16'd1, 1'b0, ring, 1'b0);

        // Edge handling: oscillates across the wrap, dies with dead edges
        load_grid(1'b1, wr);
        run(1'b1, 16'd1, B3S23, 16'd1, 1'b0, wr_exp, 1'b0);
        load_grid(1'b0, wr);
        run(1'b0, 16'd1, B3S23, 16'd1, 1'b0, 256'(0), 1'b0);

        // Reset in the 10th COMPUTE cycle of a 5-generation run
        load_grid(1'b1, gv);
        @(negedge clk);
        rule = B3S23; num_gens = 16'd5; st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy_before_reset", 256'(busy1), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 256'(busy1), 256'(0));
        chk("abort_gen_count", 256'(gc1), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        nud = 0;
        g   = '0;
        for (int i = 0; i < 16; i++) begin
            stim_row = 4'(i);
            @(negedge clk);
            g[i*16 +: 16] = rd1;
            if (ud1 === 1'b1) nud++;
        end
        repeat (100) begin
            @(negedge clk);
            if (ud1 === 1'b1) nud++;
        end
        chk("abort_grid_cleared", g, 256'(0));
        chk("abort_no_update_done", 256'(nud), 256'(0));
        chk("abort_idle_busy", 256'(busy1), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
